pipeline_param_adder: RTL and testbench
=======================================

PIPELINE_PARAM_ADDER -- requirements
Module: pipeline_param_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4: number of pipeline register stages; WIDTH % STAGES == 0 and STAGES >= 1 are required; SEG = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-008 SHALL have port sub  input  1  mode: 0 = add, 1 = subtract.
REQ-009 SHALL have port in_valid  input  1  operands valid.
REQ-010 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  carry out of MSB.
REQ-013 SHALL have port ovf  output  1  signed overflow.
REQ-014 SHALL have port out_valid  output  1  sum/cout/ovf valid.
REQ-015 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-016 SHALL compute, per transaction, add: a + b + cin; subtract: a + ~b + ~cin (i.e. a - b - cin), full WIDTH+1-bit result split into sum and cout.
REQ-017 SHALL in subtract mode report cout = 1 for no borrow, 0 for borrow.
REQ-018 SHALL set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 SHALL split the add into STAGES segments of SEG bits; stage k (1..STAGES) adds segment k-1 using the carry registered by stage k-1 (stage 1 uses cin/~cin), and carries the remaining operand bits, mode and completed sum bits forward in its register.
REQ-020 SHALL hold a valid bit per stage; transaction moves on a handshake only (in_valid && in_ready at input, out_valid && out_ready at output).
REQ-021 SHALL let stage k load when it is empty or stage k+1 loads in the same cycle (bubble-collapsing); stage STAGES loads when empty or out_ready is 1.
REQ-022 SHALL drive in_ready = stage-1 load condition, combinational from out_ready and stage valids; no combinational path from in_valid to in_ready.
REQ-023 SHALL with no stall present out_valid exactly STAGES cycles after the accepting edge, throughput one transaction per cycle.
REQ-024 SHALL drive sum, cout, ovf, out_valid directly from the last stage register.
REQ-025 SHALL hold a stalled output (out_valid 1, out_ready 0) stable until accepted; full pipeline holds exactly STAGES transactions, then in_ready = 0.
REQ-026 SHALL preserve transaction order; no loss, no duplication.
REQ-027 SHALL ignore a, b, cin, sub when in_valid = 0 or in_ready = 0.

Reset
REQ-028 SHALL on rst = 1 at a rising edge clear all stage valid bits and data registers: out_valid 0, sum 0, cout 0, ovf 0.
REQ-029 SHALL discard all in-flight transactions on reset mid-operation; no post-reset output originates from pre-reset inputs.
REQ-030 SHALL drive in_ready = 1 in the first cycle after rst deasserts, given out_ready don't-care.
REQ-031 SHALL ignore in_valid during a cycle in which rst = 1.

Verification (WIDTH=64, STAGES=4)
REQ-032 SHALL cover: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-033 SHALL cover: sub=1, a=5, b=7, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; then a=7, b=5, cin=1 -> sum=1, cout=1, ovf=0.
REQ-034 SHALL cover: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0; sub=1, a=0x8000_0000_0000_0000, b=1 -> ovf=1.
REQ-035 SHALL cover: 8 back-to-back transactions a=i, b=i (i=0..7), out_ready=0 for 6 cycles from the 2nd acceptance -> in_ready falls after 4 held, results 0,2,...,14 emerge in order, none lost or repeated, stalled output stable.
REQ-036 SHALL cover: 3 transactions in flight, rst=1 one cycle -> out_valid=0 next cycle and no result of those 3 ever appears; next transaction after reset completes normally.
REQ-037 SHALL cover: in_valid alternating 1/0, out_ready=1 -> out_valid alternates with same pattern delayed 4 cycles, random carry-propagating operands matching a reference model.

Source files
------------

// File: rtl/pipeline_param_adder.sv
`default_nettype none
// ============================================================================
// pipeline_param_adder : STAGES-deep segmented adder/subtractor, valid/ready
// Rev 1.0 : initial release
// ============================================================================
module pipeline_param_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int SEG = WIDTH / STAGES;

  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_in   [STAGES];
  logic [WIDTH-1:0]  bx_in  [STAGES];
  logic [WIDTH-1:0]  sum_in [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [STAGES-1:0] carry_d;
  logic              ovf_d;
  logic [STAGES-1:0] load;

  // Bubble-collapsing: a stage may load if it is empty or everything after it moves.
  always_comb begin
    load[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = ~valid_q[k] | load[k+1];
    end
  end

  // The subtract mode is folded in at entry (b and cin inverted once), so later
  // stages only ever add; the inverted operand travels down the pipe instead.
  always_comb begin
    a_in[0]   = a;
    bx_in[0]  = sub ? ~b : b;
    sum_in[0] = '0;
    c_in[0]   = sub ^ cin;
    v_in[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k]   = a_q[k-1];
      bx_in[k]  = bx_q[k-1];
      sum_in[k] = sum_q[k-1];
      c_in[k]   = carry_q[k-1];
      v_in[k]   = valid_q[k-1];
    end
  end

  always_comb begin
    logic [SEG:0] seg;
    seg   = '0;
    ovf_d = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      seg = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, bx_in[k][k*SEG +: SEG]}
          + {{SEG{1'b0}}, c_in[k]};
      sum_d[k]               = sum_in[k];
      sum_d[k][k*SEG +: SEG] = seg[SEG-1:0];
      carry_d[k]             = seg[SEG];
    end
    // seg now holds the top segment: carry into the MSB is recovered from its sum bit.
    ovf_d = seg[SEG] ^ (a_in[STAGES-1][WIDTH-1] ^ bx_in[STAGES-1][WIDTH-1] ^ seg[SEG-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k]     <= a_in[k];
            bx_q[k]    <= bx_in[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
      if (load[STAGES-1] && v_in[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = load[0];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign out_valid = valid_q[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_param_adder.sv
`default_nettype none
// ============================================================================
// tb_pipeline_param_adder : directed + random checks against a queue model
// Rev 1.0 : initial release
// ============================================================================
module tb_pipeline_param_adder;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a, b, sum;
  logic             cin, sub, in_valid, in_ready, cout, ovf, out_valid, out_ready;

  always #5 clk = ~clk;

  pipeline_param_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               cyc;
    int               stalls;
  } exp_t;

  exp_t             q[$];
  logic [WIDTH-1:0] got[$];
  int               n_chk = 0, n_err = 0, cyc = 0, stalls = 0;
  logic             acc_last = 1'b0, stall_prev = 1'b0, full_seen = 1'b0;
  logic [WIDTH+2:0] held = '0;

  task automatic chk(input string tag, input logic [WIDTH+2:0] obs, input logic [WIDTH+2:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned and sign-extended arithmetic, no segmenting.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s);
    exp_t             e;
    logic [WIDTH+1:0] sx, sy, r;
    logic [WIDTH:0]   u;
    sx = {{2{x[WIDTH-1]}}, x};
    sy = {{2{y[WIDTH-1]}}, y};
    if (s) begin
      r      = sx - sy - {{(WIDTH+1){1'b0}}, ci};
      u      = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};
      e.cout = ({1'b0, x} >= ({1'b0, y} + {{WIDTH{1'b0}}, ci}));
    end else begin
      r      = sx + sy + {{(WIDTH+1){1'b0}}, ci};
      u      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
      e.cout = u[WIDTH];
    end
    e.sum    = u[WIDTH-1:0];
    e.ovf    = r[WIDTH] ^ r[WIDTH-1];
    e.cyc    = 0;
    e.stalls = 0;
    return e;
  endfunction

  // One clock cycle: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc_last = 1'b0;
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("stall_hold", {out_valid, cout, ovf, sum}, held);
      chk("in_ready", {2'b0, in_ready}, {2'b0, (out_ready || q.size() < STAGES)});
      if (!in_ready) full_seen = 1'b1;
      if (q.size() == 0) begin
        chk("idle_out_valid", {2'b0, out_valid}, '0);
      end else if (out_valid && out_ready) begin
        e = q.pop_front();
        got.push_back(sum);
        chk("sum", {3'b0, sum}, {3'b0, e.sum});
        chk("cout", {2'b0, cout}, {2'b0, e.cout});
        chk("ovf", {2'b0, ovf}, {2'b0, e.ovf});
        if (e.stalls == stalls) chk("latency", cyc - e.cyc, STAGES);
      end
      if (in_valid && in_ready) begin
        e        = model(a, b, cin, sub);
        e.cyc    = cyc;
        e.stalls = stalls;
        q.push_back(e);
        acc_last = 1'b1;
      end
      if (!out_ready) stalls++;
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, cout, ovf, sum};
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic ci, input logic s);
    int n;
    n = 0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc_last && n < 50);
    chk("send_accept", {2'b0, acc_last}, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send_expect(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic ci, input logic s,
                             input logic [WIDTH-1:0] esum, input logic ecout, input logic eovf);
    int lat;
    out_ready = 1'b1;
    send(x, y, ci, s);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, STAGES);
    chk({tag, "_sum"}, {3'b0, sum}, {3'b0, esum});
    chk({tag, "_cout"}, {2'b0, cout}, {2'b0, ecout});
    chk({tag, "_ovf"}, {2'b0, ovf}, {2'b0, eovf});
    drain();
  endtask

  initial begin
    int sent, stall_left;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {2'b0, out_valid}, 0);
    chk("rst_sum", {3'b0, sum}, 0);
    chk("rst_cout", {2'b0, cout}, 0);
    chk("rst_ovf", {2'b0, ovf}, 0);
    chk("rst_in_ready", {2'b0, in_ready}, 1);

    send_expect("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    send_expect("sub_borrow", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    send_expect("sub_cin", 64'd7, 64'd5, 1'b1, 1'b1, 64'd1, 1'b1, 1'b0);
    send_expect("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    send_expect("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Eight back-to-back, output stalled six cycles after the second acceptance.
    got.delete();
    full_seen  = 1'b0;
    out_ready  = 1'b1;
    sent       = 0;
    stall_left = 0;
    for (int t = 0; t < 80 && (sent < 8 || q.size() > 0); t++) begin
      in_valid = (sent < 8);
      a = 64'(sent); b = 64'(sent); cin = 1'b0; sub = 1'b0;
      tick();
      if (acc_last) begin
        sent++;
        if (sent == 2) stall_left = 6;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    chk("b2b_full_seen", {2'b0, full_seen}, 1);
    chk("b2b_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("b2b_order", {3'b0, got[i]}, 2 * i);

    // Reset with three transactions in flight.
    out_ready = 1'b1;
    sent = 0;
    for (int t = 0; t < 10 && sent < 3; t++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'(($urandom)); sub = 1'(($urandom));
      tick();
      if (acc_last) sent++;
    end
    rst = 1'b1; in_valid = 1'b1; a = 64'd123;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", {2'b0, out_valid}, 0);
    chk("midrst_in_ready", {2'b0, in_ready}, 1);
    for (int t = 0; t < 8; t++) tick();
    send_expect("post_rst", 64'h0000_0001_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0,
                64'h0000_0002_0000_0000, 1'b0, 1'b0);

    // Alternating in_valid with carry-propagating random operands.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i % 2 == 0);
      a   = {$urandom, $urandom};
      b   = (i % 4 == 0) ? ~a : {$urandom, $urandom};
      cin = 1'(($urandom));
      sub = 1'(($urandom));
      tick();
    end
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a   = {$urandom, $urandom};
      b   = ($urandom % 3 == 0) ? ~a : {$urandom, $urandom};
      cin = 1'(($urandom));
      sub = 1'(($urandom));
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
